// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Ports: pipeline req/we/addr/wdata -> rdata/stall; mem_* multi-cycle port; hit/miss counters.
module data_cache #(
  parameter int SETS      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [31:0]          mem_rdata_i,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int IDX = $clog2(SETS);
  localparam int TW  = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_array [SETS];
  logic [31:0]     data [SETS];

  logic [IDX-1:0] index;
  logic [TW-1:0]  tag;
  logic           hit;

  logic issue;
  logic fill_en;
  logic upd_en;
  logic retire;
  logic hit_inc;
  logic miss_inc;

  // Byte-offset bits carry no meaning for word accesses.
  logic unused_offset;
  assign unused_offset = ^addr_i[1:0];

  assign index = addr_i[IDX+1:2];
  assign tag   = addr_i[31:IDX+2];
  assign hit   = req_i & valid[index] & (tag_array[index] == tag);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    stall_o  = 1'b0;
    rdata_o  = 32'h0;
    issue    = 1'b0;
    fill_en  = 1'b0;
    upd_en   = 1'b0;
    retire   = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          if (we_i) begin
            stall_o = 1'b1;
            issue   = 1'b1;
            state_n = WRITE;
          end else if (hit) begin
            rdata_o = data[index];
            hit_inc = 1'b1;
          end else begin
            stall_o  = 1'b1;
            issue    = 1'b1;
            miss_inc = 1'b1;
            state_n  = FILL;
          end
        end
      end
      FILL: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          fill_en = 1'b1;
          retire  = 1'b1;
          state_n = DONE;
        end
      end
      WRITE: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          upd_en  = hit;
          retire  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (req_i && !we_i) rdata_o = data[index];
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are forced quiet while reset is held.
    if (!rst_i) begin
      stall_o = 1'b0;
      rdata_o = 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
    end else if (issue) begin
      mem_req_o  <= 1'b1;
      mem_we_o   <= we_i;
      mem_addr_o <= {addr_i[31:2], 2'b00};
      if (we_i) mem_wdata_o <= wdata_i;
    end else if (retire) begin
      mem_req_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       valid        <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_array[index] <= tag;
      data[index]      <= mem_rdata_i;
    end else if (upd_en) begin
      data[index] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_inc && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (miss_inc && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and a multi-cycle main-memory port. It serves load hits in the request cycle and stalls the pipeline on load misses and on every store. Stalls last until main memory acknowledges. It also keeps saturating hit/miss counters for performance measurement.

## Interface
- SETS, 32: number of one-word lines; power of two; IDX = log2(SETS).
- CNT_WIDTH, 16: width of each performance counter.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  1  pipeline access valid this cycle.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data.
- stall_o  out  1  pipeline must hold all inputs and not advance.
- mem_req_o  out  1  main-memory request, held until acknowledged.
- mem_we_o  out  1  memory request is a write.
- mem_addr_o  out  32  word-aligned memory address.
- mem_wdata_o  out  32  memory write data.
- mem_ack_i  in  1  memory completes the request this cycle; read data valid.
- mem_rdata_i  in  32  memory read data, sampled with mem_ack_i.
- hit_cnt_o  out  CNT_WIDTH  load hits, saturating.
- miss_cnt_o  out  CNT_WIDTH  load misses, saturating.

## Operation
- Address split: index = addr_i[IDX+1:2]; tag = addr_i[31:IDX+2].
- Per line: a valid bit, a tag, and a 32-bit data word.
- hit = req_i & valid[index] & (tag_array[index] == tag).
- FSM states:
  - IDLE
    - Load hit: stall_o=0; rdata_o = data[index]; hit_cnt +1.
    - Load miss: stall_o=1; register mem_req_o=1, mem_we_o=0, mem_addr_o={addr_i[31:2],2'b00}; miss_cnt +1; go to FILL.
    - Store: stall_o=1; register mem_req_o=1, mem_we_o=1, address, mem_wdata_o=wdata_i; go to WRITE.
  - FILL: stall_o=1; hold all mem outputs. On mem_ack_i:
    - set valid[index]=1, tag_array[index]=tag, data[index]=mem_rdata_i;
    - drop mem_req_o; go to DONE.
  - WRITE: stall_o=1; hold mem outputs. On mem_ack_i:
    - if hit, data[index]=wdata_i (write-through update);
    - on a miss the cache is left unchanged (no allocate);
    - drop mem_req_o; go to DONE.
  - DONE: stall_o=0; the held request retires.
    - Load: rdata_o = data[index], now a hit.
    - No counter update, no memory request.
    - Next state IDLE.
- rdata_o = 32'h0 whenever the current access is not a load hit (IDLE) or in DONE after a store.
- Counters saturate at all-ones; they never wrap.
- mem_ack_i is ignored in IDLE and DONE.
- Stores are never counted.

## Timing
- Reset (rst_i=0), asynchronous:
  - state=IDLE; all valid bits cleared.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - hit_cnt_o=0, miss_cnt_o=0.
  - stall_o=0 and rdata_o=0 while rst_i=0.
- Load hit: zero stall cycles; rdata_o combinational in the request cycle.
- Miss or store, with the ack arriving in the Nth cycle that mem_req_o is high (N≥1):
  - stall_o high for N+1 cycles (the request cycle plus N cycles in FILL/WRITE);
  - DONE follows, with stall_o=0.
- mem_req_o rises the cycle after the request cycle. It falls the cycle after the ack.
- Reset during FILL/WRITE aborts the operation:
  - mem_req_o drops immediately;
  - no line is written;
  - state returns to IDLE.
- Data, tag and valid arrays need no reset beyond the valid bits.

## Test plan
- Reset then load 0x40, memory acks in 1st cycle with 0x11111111:
  - stall_o high 2 cycles; DONE rdata_o=0x11111111;
  - miss_cnt_o=1, hit_cnt_o=0.
- Load miss 0x40, ack in 3rd cycle with 0xDEADBEEF:
  - stall_o high 4 cycles; DONE rdata_o=0xDEADBEEF.
  - Repeat load 0x40: stall_o=0, rdata_o=0xDEADBEEF same cycle, hit_cnt_o=1.
- Conflict (SETS=32): fill 0x40=0xAAAA0000, then load 0xC0 (same index 16):
  - 0xC0 misses; fill with 0xBBBB0000;
  - reload 0x40 misses again; miss_cnt_o=3.
- Store 0x40=0x12345678 while line valid:
  - mem_we_o=1, mem_wdata_o=0x12345678;
  - after ack, load 0x40 hits with 0x12345678.
- Store 0x200 with line invalid: memory write occurs; following load 0x200 misses.
- Reset asserted mid-FILL:
  - mem_req_o=0 immediately; counters 0;
  - load 0x40 after reset misses.
- CNT_WIDTH=4, 20 load hits: hit_cnt_o holds 15.
